// File: rtl/formation_pkg.sv
// formation_pkg: shared direction/state types, extent widths and the speed-up period helper
// used when FORMATION_SPEEDUP_EN is defined.
package formation_pkg;
    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CHECK, S_MOVE, S_DOWN, S_HALT} state_t;
    localparam int FCNT_W = 8;
    localparam int MASK_MAX = 256;
    function automatic int ext_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    // Fewer survivors give a shorter frame period.
    function automatic logic [FCNT_W-1:0] speedup_period(input logic [MASK_MAX-1:0] m);
        int c;
        c = 0;
        for (int i = 0; i < MASK_MAX; i++) c += int'(m[i]);
        return FCNT_W'(1 + (c >> 2));
    endfunction
endpackage

// File: rtl/formation_extent.sv
// formation_extent: leftmost/rightmost live column and bottom live row of the alive mask.
module formation_extent import formation_pkg::*; #(
    parameter int ROWS = 5,
    parameter int COLS = 11
) (
    input  logic [ROWS*COLS-1:0]    alive_i,
    output logic [ext_w(COLS)-1:0]  lmin_o,
    output logic [ext_w(COLS)-1:0]  rmax_o,
    output logic [ext_w(ROWS)-1:0]  bmax_o,
    output logic                    any_o
);
    localparam int CW = ext_w(COLS);
    localparam int RW = ext_w(ROWS);
    logic [COLS-1:0] col_or;
    logic [ROWS-1:0] row_or;
    always_comb begin
        col_or = '0;
        row_or = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                col_or[c] = col_or[c] | alive_i[r*COLS+c];
                row_or[r] = row_or[r] | alive_i[r*COLS+c];
            end
        lmin_o = '0;
        rmax_o = '0;
        bmax_o = '0;
        for (int c = COLS - 1; c >= 0; c--) if (col_or[c]) lmin_o = CW'(c);
        for (int c = 0; c < COLS; c++) if (col_or[c]) rmax_o = CW'(c);
        for (int r = 0; r < ROWS; r++) if (row_or[r]) bmax_o = RW'(r);
    end
    assign any_o = |alive_i;
endmodule

// File: rtl/alien_formation_ctrl.sv
// alien_formation_ctrl: frame-paced march/descend/reverse of the invader grid plus alive mask.
// Define FORMATION_SPEEDUP_EN to shorten the step period as aliens die.
module alien_formation_ctrl import formation_pkg::*; #(
    parameter int CORDW       = 16,
    parameter int ROWS        = 5,
    parameter int COLS        = 11,
    parameter int CELL_W      = 16,
    parameter int CELL_H      = 16,
    parameter int SPR_W       = 12,
    parameter int SPR_H       = 8,
    parameter int STEP_X      = 2,
    parameter int STEP_Y      = 8,
    parameter int STEP_FRAMES = 16,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int LAND_Y      = 440,
    parameter int START_X     = 48,
    parameter int START_Y     = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    frame,
    input  logic                    kill_valid,
    input  logic [ext_w(ROWS)-1:0]  kill_row,
    input  logic [ext_w(COLS)-1:0]  kill_col,
    output logic                    kill_hit,
    output logic signed [CORDW-1:0] form_x,
    output logic signed [CORDW-1:0] form_y,
    output logic [ROWS*COLS-1:0]    alive,
    output logic                    anim_sel,
    output logic                    step_pulse,
    output logic                    landed,
    output logic                    cleared
);
    localparam int N  = ROWS * COLS;
    localparam int RW = ext_w(ROWS);
    localparam int CW = ext_w(COLS);
    localparam int IW = ext_w(N);
    localparam int EW = CORDW + 2;

    state_t state_q, state_d;
    dir_t dir_q, dir_d;
    logic signed [CORDW-1:0] form_x_q, form_x_d, form_y_q, form_y_d;
    logic [N-1:0] alive_q, alive_d;
    logic [FCNT_W-1:0] cnt_q, cnt_d, period;
    logic anim_q, anim_d, kill_hit_q, kill_hit_d, step_q, step_d;
    logic landed_q, landed_d, cleared_q, cleared_d;
    logic [CW-1:0] lmin, rmax;
    logic [RW-1:0] bmax;
    logic any_alive, active, at_edge, on_ground;
    logic [IW-1:0] kidx;
    logic signed [EW-1:0] r_edge, l_edge, bot;

    formation_extent #(.ROWS(ROWS), .COLS(COLS)) u_extent (
        .alive_i (alive_q),
        .lmin_o  (lmin),
        .rmax_o  (rmax),
        .bmax_o  (bmax),
        .any_o   (any_alive)
    );

`ifdef FORMATION_SPEEDUP_EN
    logic [FCNT_W-1:0] period_q, period_d;
    assign period = period_q;
    always_ff @(posedge clk)
        if (rst) period_q <= speedup_period(MASK_MAX'({N{1'b1}}));
        else period_q <= period_d;
`else
    assign period = FCNT_W'(STEP_FRAMES);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            form_x_q   <= CORDW'(START_X);
            form_y_q   <= CORDW'(START_Y);
            alive_q    <= '1;
            dir_q      <= DIR_RIGHT;
            anim_q     <= 1'b0;
            cnt_q      <= '0;
            kill_hit_q <= 1'b0;
            step_q     <= 1'b0;
            landed_q   <= 1'b0;
            cleared_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            form_x_q   <= form_x_d;
            form_y_q   <= form_y_d;
            alive_q    <= alive_d;
            dir_q      <= dir_d;
            anim_q     <= anim_d;
            cnt_q      <= cnt_d;
            kill_hit_q <= kill_hit_d;
            step_q     <= step_d;
            landed_q   <= landed_d;
            cleared_q  <= cleared_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        form_x_d   = form_x_q;
        form_y_d   = form_y_q;
        alive_d    = alive_q;
        dir_d      = dir_q;
        anim_d     = anim_q;
        cnt_d      = cnt_q;
        kill_hit_d = 1'b0;
        step_d     = 1'b0;
        landed_d   = landed_q;
        cleared_d  = cleared_q;
`ifdef FORMATION_SPEEDUP_EN
        period_d   = period_q;
`endif
        active = state_q inside {S_WAIT, S_CHECK, S_MOVE, S_DOWN};
        kidx = IW'(kill_row) * IW'(COLS) + IW'(kill_col);
        if (active && kill_valid && int'(kill_row) < ROWS && int'(kill_col) < COLS) begin
            kill_hit_d    = alive_q[kidx];
            alive_d[kidx] = 1'b0;
        end
        // Extents come from the registered mask, so a same-cycle kill cannot move an edge.
        r_edge = EW'(form_x_q) + EW'(rmax) * EW'(CELL_W) + EW'(SPR_W - 1 + STEP_X);
        l_edge = EW'(form_x_q) + EW'(lmin) * EW'(CELL_W) - EW'(STEP_X);
        bot = EW'(form_y_q) + EW'(bmax) * EW'(CELL_H) + EW'(SPR_H);
        at_edge = (dir_q == DIR_RIGHT) ? (r_edge > EW'(X_MAX)) : (l_edge < EW'(X_MIN));
        on_ground = bot >= EW'(LAND_Y);
        if (active && !any_alive) begin
            cleared_d = 1'b1;
            state_d   = S_HALT;
        end else begin
            case (state_q)
                S_WAIT: if (frame) begin
                    if (cnt_q == period - 1'b1) begin
                        cnt_d   = '0;
                        state_d = S_CHECK;
`ifdef FORMATION_SPEEDUP_EN
                        period_d = speedup_period(MASK_MAX'(alive_q));
`endif
                    end else cnt_d = cnt_q + 1'b1;
                end
                S_CHECK: begin
                    anim_d = ~anim_q;
                    step_d = 1'b1;
                    if (at_edge) begin
                        form_y_d = form_y_q + CORDW'(STEP_Y);
                        dir_d    = (dir_q == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
                        state_d  = S_DOWN;
                    end else begin
                        form_x_d = (dir_q == DIR_RIGHT) ? form_x_q + CORDW'(STEP_X) : form_x_q - CORDW'(STEP_X);
                        state_d  = S_MOVE;
                    end
                end
                S_MOVE: state_d = S_WAIT;
                S_DOWN: begin
                    landed_d = landed_q | on_ground;
                    state_d  = on_ground ? S_HALT : S_WAIT;
                end
                default: ;
            endcase
        end
        if (start) begin
            state_d    = S_WAIT;
            form_x_d   = CORDW'(START_X);
            form_y_d   = CORDW'(START_Y);
            alive_d    = '1;
            dir_d      = DIR_RIGHT;
            anim_d     = 1'b0;
            cnt_d      = '0;
            kill_hit_d = 1'b0;
            step_d     = 1'b0;
            landed_d   = 1'b0;
            cleared_d  = 1'b0;
`ifdef FORMATION_SPEEDUP_EN
            period_d   = speedup_period(MASK_MAX'({N{1'b1}}));
`endif
        end
    end

    assign form_x     = form_x_q;
    assign form_y     = form_y_q;
    assign alive      = alive_q;
    assign anim_sel   = anim_q;
    assign kill_hit   = kill_hit_q;
    assign step_pulse = step_q;
    assign landed     = landed_q;
    assign cleared    = cleared_q;
endmodule

// File: tb/tb_alien_formation_ctrl.sv
// tb_alien_formation_ctrl: directed sequences, a kill vector table and random traffic
// checked every cycle against a step-level model of the formation rules.
module tb_alien_formation_ctrl;
    logic clk = 1'b0;
    logic rst, start, frame, kill_valid;
    logic [2:0] kill_row;
    logic [3:0] kill_col;
    logic kh_a, an_a, sp_a, ld_a, cl_a, kh_b, an_b, sp_b, ld_b, cl_b;
    logic signed [15:0] fx_a, fy_a, fx_b, fy_b;
    logic [54:0] al_a, al_b;
    int checks = 0;
    int errors = 0;
    int b_steps = 0;

    always #5 clk = ~clk;

    alien_formation_ctrl #(.X_MAX(239)) dut_a (
        .clk(clk), .rst(rst), .start(start), .frame(frame), .kill_valid(kill_valid),
        .kill_row(kill_row), .kill_col(kill_col), .kill_hit(kh_a), .form_x(fx_a), .form_y(fy_a),
        .alive(al_a), .anim_sel(an_a), .step_pulse(sp_a), .landed(ld_a), .cleared(cl_a)
    );
    alien_formation_ctrl #(.X_MAX(239), .LAND_Y(140)) dut_b (
        .clk(clk), .rst(rst), .start(start), .frame(frame), .kill_valid(kill_valid),
        .kill_row(kill_row), .kill_col(kill_col), .kill_hit(kh_b), .form_x(fx_b), .form_y(fy_b),
        .alive(al_b), .anim_sel(an_b), .step_pulse(sp_b), .landed(ld_b), .cleared(cl_b)
    );

    // Reference model for dut_a: mode 0 idle, 1 running, 2 halted; busy counts the
    // two cycles between a qualifying frame and the next counted frame.
    int m_x, m_y, m_dir, m_anim, m_mode, m_busy, m_cnt, m_desc;
    bit m_hit, m_step, m_land, m_clr;
    bit m_alive[55];

    function automatic void model_init(input int mode);
        m_x = 48; m_y = 64; m_dir = 1; m_anim = 0; m_mode = mode; m_busy = 0; m_cnt = 0;
        m_desc = 0; m_hit = 0; m_step = 0; m_land = 0; m_clr = 0;
        foreach (m_alive[i]) m_alive[i] = 1'b1;
    endfunction

    function automatic void model_edge(input bit do_rst, do_start, f, kv, input int kr, input int kc);
        int lmin, rmax, bmax, n;
        if (do_rst) begin model_init(0); return; end
        if (do_start) begin model_init(1); return; end
        m_hit = 0;
        m_step = 0;
        if (m_mode != 1) return;
        lmin = 99; rmax = -1; bmax = -1; n = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 11; c++)
                if (m_alive[r*11+c]) begin
                    n++;
                    if (c < lmin) lmin = c;
                    if (c > rmax) rmax = c;
                    if (r > bmax) bmax = r;
                end
        if (kv && kr < 5 && kc < 11) begin
            m_hit = m_alive[kr*11+kc];
            m_alive[kr*11+kc] = 1'b0;
        end
        if (n == 0) begin m_clr = 1; m_mode = 2; return; end
        if (m_busy == 0) begin
            if (f) begin
                if (m_cnt == 15) begin m_cnt = 0; m_busy = 1; end
                else m_cnt++;
            end
        end else if (m_busy == 1) begin
            m_desc = (m_dir > 0) ? int'(m_x + rmax*16 + 11 + 2 > 239) : int'(m_x + lmin*16 - 2 < 0);
            if (m_desc != 0) begin m_y += 8; m_dir = -m_dir; end
            else m_x += 2 * m_dir;
            m_anim ^= 1;
            m_step = 1;
            m_busy = 2;
        end else begin
            m_busy = 0;
            if (m_desc != 0 && m_y + bmax*16 + 8 >= 440) begin m_land = 1; m_mode = 2; end
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [63:0] e;
        e = '0;
        for (int i = 0; i < 55; i++) e[i] = m_alive[i];
        chk("model_form_x", 64'(fx_a), 64'(m_x));
        chk("model_form_y", 64'(fy_a), 64'(m_y));
        chk("model_alive", 64'(al_a), e);
        chk("model_anim", 64'(an_a), 64'(m_anim));
        chk("model_step", 64'(sp_a), 64'(m_step));
        chk("model_kill_hit", 64'(kh_a), 64'(m_hit));
        chk("model_landed", 64'(ld_a), 64'(m_land));
        chk("model_cleared", 64'(cl_a), 64'(m_clr));
    endtask

    task automatic cyc(input bit r, s, f, kv, input int kr, input int kc);
        rst = r; start = s; frame = f; kill_valid = kv;
        kill_row = 3'(kr); kill_col = 4'(kc);
        @(posedge clk);
        model_edge(r, s, f, kv, kr & 7, kc & 15);
        @(negedge clk);
        if (sp_b) b_steps++;
        compare_model();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            cyc(0, 0, 1, 0, 0, 0);
            idle(3);
        end
    endtask

    task automatic steps(input int n);
        frames(16 * n);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, 64'(fx_a), 64'(48));
        chk({tag, "_y"}, 64'(fy_a), 64'(64));
        chk({tag, "_alive"}, 64'(al_a), {9'd0, {55{1'b1}}});
        chk({tag, "_anim"}, 64'(an_a), 64'(0));
        chk({tag, "_step"}, 64'(sp_a), 64'(0));
        chk({tag, "_landed"}, 64'(ld_a), 64'(0));
        chk({tag, "_cleared"}, 64'(cl_a), 64'(0));
    endtask

    typedef struct {
        bit kv;
        int row;
        int col;
        bit hit;
    } kill_vec_t;

    initial begin
        kill_vec_t kv_tab[7];
        kv_tab[0] = '{1, 2, 3, 1};
        kv_tab[1] = '{1, 2, 3, 0};
        kv_tab[2] = '{1, 0, 11, 0};
        kv_tab[3] = '{1, 5, 0, 0};
        kv_tab[4] = '{1, 4, 10, 1};
        kv_tab[5] = '{1, 0, 0, 1};
        kv_tab[6] = '{0, 1, 1, 0};
        rst = 1; start = 0; frame = 0; kill_valid = 0; kill_row = 0; kill_col = 0;
        model_init(0);
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0);
        chk_reset_vals("reset");
        chk("reset_kill_hit", 64'(kh_a), 64'(0));
        // march right once; position lands two edges after the 16th frame
        cyc(0, 1, 0, 0, 0, 0);
        frames(15);
        cyc(0, 0, 1, 0, 0, 0);
        chk("lat1_x", 64'(fx_a), 64'(48));
        cyc(0, 0, 0, 0, 0, 0);
        chk("lat2_x", 64'(fx_a), 64'(50));
        chk("lat2_step", 64'(sp_a), 64'(1));
        chk("lat2_anim", 64'(an_a), 64'(1));
        idle(2);
        chk("step_once", 64'(sp_a), 64'(0));
        // right edge: 68+160+11 = 239 is the last legal position
        steps(9);
        chk("edge_x", 64'(fx_a), 64'(68));
        chk("edge_y", 64'(fy_a), 64'(64));
        steps(1);
        chk("desc_x", 64'(fx_a), 64'(68));
        chk("desc_y", 64'(fy_a), 64'(72));
        steps(1);
        chk("left_x", 64'(fx_a), 64'(66));
        // kill vector table
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, kv_tab[i].kv, kv_tab[i].row, kv_tab[i].col);
            chk($sformatf("kill_hit_%0d", i), 64'(kh_a), 64'(kv_tab[i].hit));
            if (kv_tab[i].hit) chk($sformatf("kill_bit_%0d", i), 64'(al_a[kv_tab[i].row*11+kv_tab[i].col]), 64'(0));
        end
        chk("alive25", 64'(al_a[25]), 64'(0));
        // without column 10 the descent moves 16 px further right
        cyc(0, 1, 0, 0, 0, 0);
        for (int r = 0; r < 5; r++) cyc(0, 0, 0, 1, r, 10);
        steps(18);
        chk("col10_x", 64'(fx_a), 64'(84));
        chk("col10_y", 64'(fy_a), 64'(64));
        steps(1);
        chk("col10_desc_x", 64'(fx_a), 64'(84));
        chk("col10_desc_y", 64'(fy_a), 64'(72));
        // landing on the low-ground instance
        cyc(0, 1, 0, 0, 0, 0);
        b_steps = 0;
        steps(10);
        chk("b_not_landed", 64'(ld_b), 64'(0));
        steps(1);
        chk("b_land_y", 64'(fy_b), 64'(72));
        chk("b_land_x", 64'(fx_b), 64'(68));
        chk("b_landed", 64'(ld_b), 64'(1));
        chk("b_steps", 64'(b_steps), 64'(11));
        steps(2);
        chk("b_halt_steps", 64'(b_steps), 64'(11));
        chk("b_halt_y", 64'(fy_b), 64'(72));
        chk("b_halt_landed", 64'(ld_b), 64'(1));
        // wipe out the wave
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 55; i++) begin
            cyc(0, 0, 0, 1, i / 11, i % 11);
            if (i == 54) begin
                chk("last_kill_hit", 64'(kh_a), 64'(1));
                chk("last_kill_clr", 64'(cl_a), 64'(0));
            end
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk("cleared", 64'(cl_a), 64'(1));
        steps(1);
        chk("cleared_hold", 64'(cl_a), 64'(1));
        cyc(0, 1, 0, 0, 0, 0);
        chk_reset_vals("restart");
        // reset in the middle of a descent
        steps(10);
        frames(15);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("down_y", 64'(fy_a), 64'(72));
        chk("down_step", 64'(sp_a), 64'(1));
        cyc(1, 0, 0, 0, 0, 0);
        chk_reset_vals("rst_down");
        cyc(0, 1, 0, 0, 0, 0);
        steps(1);
        chk("rst_dir_x", 64'(fx_a), 64'(50));
        // random traffic against the model
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 999) == 0, $urandom_range(0, 399) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 7) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
